// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the keypad entry block: special key codes, the
// debounce FSM state type and default parameter values.
// Optional feature macro used by keypad_entry: KEYPAD_ENTRY_SYNC_EN.
package keypad_pkg;

    localparam logic [3:0] KEY_STAR = 4'hA;  // clears the entry buffer
    localparam logic [3:0] KEY_HASH = 4'hB;  // submits the entered code

    localparam int DEFAULT_DB_CYCLES = 16;
    localparam int DEFAULT_NDIGITS   = 4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        PRESSED    = 2'd2,
        RELEASE_DB = 2'd3
    } dbState_e;

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce
// Debounces the decoded keypad inputs and issues exactly one press event per
// accepted key press. Releases are debounced too, so a short dropout while a
// key is held does not produce a second press.
// Parameters:
//   DB_CYCLES  consecutive stable cycles to accept a press or release (>= 2)
// Ports:
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset
//   keyValue   4-bit key code from the decoder
//   keyValid   high while exactly one key is decoded
//   press_evt  one-cycle pulse, registered, when a press is accepted
//   press_val  key code belonging to press_evt (latched at press start)
//   state      current debounce state, for observation
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DB_CYCLES = DEFAULT_DB_CYCLES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] keyValue,
    input  logic       keyValid,
    output logic       press_evt,
    output logic [3:0] press_val,
    output dbState_e   state
);

    localparam int CNT_W = $clog2(DB_CYCLES);

    // The cycle that enters PRESS_DB / RELEASE_DB is the first stable cycle,
    // so the counter completing at DB_CYCLES-1 means DB_CYCLES stable cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 2);

    logic [CNT_W-1:0] cnt;
    logic             sameKey;

    assign sameKey = keyValid && (keyValue == press_val);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            press_val <= '0;
            press_evt <= 1'b0;
        end else begin
            press_evt <= 1'b0;
            case (state)
                IDLE: begin
                    if (keyValid) begin
                        state     <= PRESS_DB;
                        press_val <= keyValue;
                        cnt       <= '0;
                    end
                end
                PRESS_DB: begin
                    if (!sameKey) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state     <= PRESSED;
                        press_evt <= 1'b1;
                        cnt       <= cnt + CNT_W'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    // Value changes while held are ignored; only a drop of
                    // keyValid starts the release check.
                    if (!keyValid) begin
                        state <= RELEASE_DB;
                        cnt   <= '0;
                    end
                end
                RELEASE_DB: begin
                    if (keyValid) begin
                        state <= PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// keypad_entry
// Collects debounced keypad presses into an NDIGITS-digit BCD code.
// Digits shift in at [3:0]; '#' submits a full code, '*' clears the entry.
// Optional macro KEYPAD_ENTRY_SYNC_EN adds a 2-flop synchronizer on the
// keypad inputs (press latency becomes DB_CYCLES+2 instead of DB_CYCLES).
// Parameters:
//   DB_CYCLES    debounce length in cycles (>= 2)
//   NDIGITS      digits per code (>= 2)
// Ports:
//   clk          clock, rising edge
//   reset_n      asynchronous active-low reset
//   key_value    decoder code: 0-9 digits, 4'hA '*', 4'hB '#', C-F unused
//   key_valid    high while exactly one key is decoded
//   code         entered digits, newest in [3:0]
//   digit_count  number of digits held
//   code_valid   complete code submitted; held until code_ack
//   code_ack     consumer acknowledge; accepted only while code_valid=1
//   overflow     sticky: a digit was pressed with the buffer full
//   entry_err    one-cycle pulse: '#' pressed with too few digits
//   dbgState     debounce FSM state, for observation
// Handshake: code_valid rises one cycle after an accepted '#'; the consumer
// samples code while code_valid=1 and raises code_ack; on the edge where
// code_ack=1 and code_valid=1 the buffer clears and code_valid drops.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int DB_CYCLES = DEFAULT_DB_CYCLES,
    parameter int NDIGITS   = DEFAULT_NDIGITS
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [3:0]                   key_value,
    input  logic                         key_valid,
    output logic [4*NDIGITS-1:0]         code,
    output logic [$clog2(NDIGITS+1)-1:0] digit_count,
    output logic                         code_valid,
    input  logic                         code_ack,
    output logic                         overflow,
    output logic                         entry_err,
    output dbState_e                     dbgState
);

    localparam int CW = $clog2(NDIGITS + 1);
    localparam logic [CW-1:0] FULL = CW'(NDIGITS);

    logic [3:0] keyValueS;
    logic       keyValidS;
    logic       pressEvt;
    logic [3:0] pressVal;
    logic       ackTake;
    logic       isDigit;

`ifdef KEYPAD_ENTRY_SYNC_EN
    // The value bus may skew across the sync stages, but the debouncer only
    // accepts a value that is stable for DB_CYCLES, which masks the skew.
    logic [3:0] valueMeta;
    logic       validMeta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valueMeta <= '0;
            validMeta <= 1'b0;
            keyValueS <= '0;
            keyValidS <= 1'b0;
        end else begin
            valueMeta <= key_value;
            validMeta <= key_valid;
            keyValueS <= valueMeta;
            keyValidS <= validMeta;
        end
    end
`else
    assign keyValueS = key_value;
    assign keyValidS = key_valid;
`endif

    keypad_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) uDebounce (
        .clk       (clk),
        .reset_n   (reset_n),
        .keyValue  (keyValueS),
        .keyValid  (keyValidS),
        .press_evt (pressEvt),
        .press_val (pressVal),
        .state     (dbgState)
    );

    assign ackTake = code_ack && code_valid;
    assign isDigit = (pressVal <= 4'd9);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            code        <= '0;
            digit_count <= '0;
            code_valid  <= 1'b0;
            overflow    <= 1'b0;
            entry_err   <= 1'b0;
        end else begin
            entry_err <= 1'b0;
            // An accepted acknowledge wins; a press in the same cycle is dropped.
            if (ackTake) begin
                code        <= '0;
                digit_count <= '0;
                code_valid  <= 1'b0;
                overflow    <= 1'b0;
            end else if (pressEvt) begin
                if (isDigit) begin
                    if (!code_valid) begin
                        if (digit_count != FULL) begin
                            code        <= {code[4*NDIGITS-5:0], pressVal};
                            digit_count <= digit_count + CW'(1);
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end else if (pressVal == KEY_STAR) begin
                    code        <= '0;
                    digit_count <= '0;
                    code_valid  <= 1'b0;
                    overflow    <= 1'b0;
                end else if (pressVal == KEY_HASH) begin
                    if (!code_valid) begin
                        if (digit_count == FULL) begin
                            code_valid <= 1'b1;
                        end else begin
                            entry_err <= 1'b1;
                        end
                    end
                end
                // Codes C-F: debounced but otherwise ignored.
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry
// Directed scenarios followed by a randomized key sequence, checked against a
// digit-queue model of the entry rules.
module tb_keypad_entry;
  import keypad_pkg::*;

  localparam int DB = 4;
  localparam int ND = 4;

  logic        clk;
  logic        reset_n;
  logic [3:0]  key_value;
  logic        key_valid;
  logic [15:0] code;
  logic [2:0]  digit_count;
  logic        code_valid;
  logic        code_ack;
  logic        overflow;
  logic        entry_err;
  dbState_e    dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  int err_cycles = 0;

  // reference model state
  int          m_digits[$];
  bit          m_valid;
  bit          m_ovf;
  int          m_err;
  logic [15:0] exp_q[$];

  keypad_entry #(.DB_CYCLES(DB), .NDIGITS(ND)) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .key_value   (key_value),
    .key_valid   (key_valid),
    .code        (code),
    .digit_count (digit_count),
    .code_valid  (code_valid),
    .code_ack    (code_ack),
    .overflow    (overflow),
    .entry_err   (entry_err),
    .dbgState    (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (entry_err === 1'b1) err_cycles++;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_code();
    logic [15:0] v = '0;
    foreach (m_digits[i]) v = {v[11:0], 4'(m_digits[i])};
    return v;
  endfunction

  function automatic void model_clear();
    m_digits.delete();
    m_valid = 1'b0;
    m_ovf = 1'b0;
  endfunction

  function automatic void model_key(input int v);
    if (v <= 9) begin
      if (!m_valid) begin
        if (m_digits.size() < ND) m_digits.push_back(v);
        else m_ovf = 1'b1;
      end
    end else if (v == 10) begin
      model_clear();
    end else if (v == 11) begin
      if (!m_valid) begin
        if (m_digits.size() == ND) begin
          m_valid = 1'b1;
          exp_q.push_back(model_code());
        end else begin
          m_err++;
        end
      end
    end
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".code"}, 32'(code), 32'(model_code()));
    check({tag, ".count"}, 32'(digit_count), 32'(m_digits.size()));
    check({tag, ".valid"}, 32'(code_valid), 32'(m_valid));
    check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".errs"}, 32'(err_cycles), 32'(m_err));
  endtask

  // driver tasks
  task automatic press_key(input int v, input int hold, input int rel);
    key_value = 4'(v);
    key_valid = 1'b1;
    step(hold);
    key_valid = 1'b0;
    step(rel);
    model_key(v);
  endtask

  task automatic do_ack();
    logic [15:0] e;
    if (m_valid) begin
      e = exp_q.pop_front();
      check("ack.code_before", 32'(code), 32'(e));
    end
    code_ack = 1'b1;
    step(1);
    code_ack = 1'b0;
    if (m_valid) model_clear();
  endtask

  initial begin
    int e0;
    int r;
    reset_n = 1'b0;
    key_value = '0;
    key_valid = 1'b0;
    code_ack = 1'b0;
    model_clear();
    m_err = 0;

    #12;
    check_all("reset");
    check("reset.state", 32'(dbg_state), 32'(IDLE));
    check("reset.entry_err", 32'(entry_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step(2);

    // full code and acknowledge
    press_key(7, 10, 10);
    press_key(5, 10, 10);
    press_key(3, 10, 10);
    press_key(9, 10, 10);
    press_key(11, 10, 10);
    check_all("full");
    check("full.code_const", 32'(code), 32'h7539);
    check("full.valid_const", 32'(code_valid), 32'd1);
    do_ack();
    check_all("ack");
    check("ack.count_const", 32'(digit_count), 32'd0);
    do_ack();  // ignored while code_valid=0
    check_all("ack_idle");

    // 3-cycle glitch is rejected, 4-cycle press accepted
    key_value = 4'd2;
    key_valid = 1'b1;
    step(3);
    key_valid = 1'b0;
    step(10);
    check_all("glitch3");
    check("glitch3.count_const", 32'(digit_count), 32'd0);
    press_key(2, 4, 10);
    check_all("hold4");
    check("hold4.count_const", 32'(digit_count), 32'd1);

    // dropout during a long hold gives one digit
    press_key(10, 6, 6);
    key_value = 4'd5;
    key_valid = 1'b1;
    step(24);
    key_valid = 1'b0;
    step(2);
    key_valid = 1'b1;
    step(24);
    key_valid = 1'b0;
    step(10);
    model_key(5);
    check_all("dropout");
    check("dropout.count_const", 32'(digit_count), 32'd1);

    // overflow then clear
    press_key(10, 6, 6);
    press_key(1, 5, 5);
    press_key(2, 5, 5);
    press_key(3, 5, 5);
    press_key(4, 5, 5);
    press_key(6, 5, 5);
    check_all("ovf");
    check("ovf.code_const", 32'(code), 32'h1234);
    press_key(10, 5, 5);
    check_all("star");

    // '#' with too few digits
    press_key(1, 5, 5);
    press_key(2, 5, 5);
    e0 = err_cycles;
    press_key(11, 5, 8);
    check("short_hash.pulse_cycles", 32'(err_cycles - e0), 32'd1);
    check_all("short_hash");

    // value change during press debounce restarts the debounce
    key_value = 4'd5;
    key_valid = 1'b1;
    step(2);
    key_value = 4'd6;
    step(1);
    check("change.state", 32'(dbg_state), 32'(IDLE));
    step(9);
    key_valid = 1'b0;
    step(10);
    model_key(6);
    check_all("change");

    // reset in PRESS_DB with three digits held
    key_value = 4'd8;
    key_valid = 1'b1;
    step(2);
    #2;
    reset_n = 1'b0;
    key_valid = 1'b0;
    #1;
    model_clear();
    check_all("midreset");
    check("midreset.state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    step(12);
    check_all("after_reset");

    // randomized key sequence
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 19);
      if (r < 11) press_key(r % 10, $urandom_range(DB, 10), $urandom_range(DB, 10));
      else if (r < 13) press_key(11, $urandom_range(DB, 10), $urandom_range(DB, 10));
      else if (r == 13) press_key(10, $urandom_range(DB, 10), $urandom_range(DB, 10));
      else if (r == 14) press_key(12 + $urandom_range(0, 3), $urandom_range(DB, 10), $urandom_range(DB, 10));
      else do_ack();
      check_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 Parameter DB_CYCLES, default 16, consecutive stable cycles required to accept a press or a release.
REQ-002 Parameter NDIGITS, default 4, digits per entered code.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 key_value  input  4  keypad decoder code: 0-9 digits, 4'hA '*', 4'hB '#', 4'hC-4'hF unused.
REQ-006 key_valid  input  1  high while exactly one key is decoded.
REQ-007 code  output  4*NDIGITS  BCD digits entered, newest in bits [3:0].
REQ-008 digit_count  output  clog2(NDIGITS+1)  digits currently held.
REQ-009 code_valid  output  1  completed code available; held until acknowledged.
REQ-010 code_ack  input  1  consumer acknowledge of code_valid.
REQ-011 overflow  output  1  sticky; a digit was pressed with the buffer full.
REQ-012 entry_err  output  1  one-cycle pulse; '#' pressed with digit_count < NDIGITS.

Function
REQ-013 Debounce FSM states: IDLE, PRESS_DB, PRESSED, RELEASE_DB.
REQ-014 IDLE -> PRESS_DB when key_valid=1; key_value is latched and the counter is cleared.
REQ-015 PRESS_DB: the counter increments while key_valid=1 and key_value equals the latched value; any mismatch or key_valid=0 returns to IDLE.
REQ-016 PRESS_DB -> PRESSED when the counter reaches DB_CYCLES-1; exactly one press event carrying the latched value is issued in that transition cycle.
REQ-017 PRESSED -> RELEASE_DB on key_valid=0; any key_value change while key_valid=1 is ignored and issues no event.
REQ-018 RELEASE_DB -> IDLE after DB_CYCLES consecutive key_valid=0 cycles; key_valid=1 before that returns to PRESSED with no event.
REQ-019 Digit event with digit_count<NDIGITS and code_valid=0: code shifts left 4 bits, the digit enters [3:0], and digit_count increments, all in the event cycle.
REQ-020 Digit event with digit_count==NDIGITS: the digit is discarded and overflow is set.
REQ-021 '*' event: code, digit_count and overflow are cleared, and code_valid is cleared if set.
REQ-022 '#' event: if digit_count==NDIGITS, code_valid is set the next cycle; otherwise entry_err pulses for one cycle and the buffer is unchanged.
REQ-023 While code_valid=1, digit and '#' events are ignored and code is stable.
REQ-024 code_ack=1 with code_valid=1 clears code_valid, code, digit_count and overflow on the next edge; code_ack while code_valid=0 has no effect.
REQ-025 A press event in the same cycle as an accepted code_ack is discarded.
REQ-026 Codes 4'hC-4'hF are debounced normally but their events have no effect.

Reset
REQ-027 When reset_n=0: FSM=IDLE, counter=0, code=0, digit_count=0, code_valid=0, overflow=0, entry_err=0, and synchronizer flops=0, all asynchronously.
REQ-028 Reset asserted mid-debounce or mid-entry discards all partial state; no event is issued on reset release.

Configuration
REQ-029 With KEYPAD_ENTRY_SYNC_EN defined, key_value and key_valid pass through a 2-flop synchronizer, and press-event latency from stable input is DB_CYCLES+2 cycles.
REQ-030 Without KEYPAD_ENTRY_SYNC_EN, the inputs are used directly and latency is DB_CYCLES cycles.

Structure
REQ-031 Shared package keypad_pkg holds the key code constants (KEY_STAR=4'hA, KEY_HASH=4'hB), the debounce state enum, and the default DB_CYCLES/NDIGITS values.
REQ-032 The debounce FSM and counter form sub-module keypad_debounce, which outputs press_evt and press_val; keypad_entry holds the buffer logic.

Verification (DB_CYCLES=4, NDIGITS=4, sync off)
REQ-033 Keys 7,5,3,9 are each held for 10 cycles and released for 10 cycles, then '#' -> code=16'h7539, digit_count=4, code_valid=1; code_ack -> all fields clear the next cycle.
REQ-034 key_valid glitches high for 3 cycles -> no event and digit_count remains 0; held for 4 cycles -> exactly one event.
REQ-035 Key 5 is held for 50 cycles with a 2-cycle dropout mid-hold -> one digit only, digit_count=1.
REQ-036 Five digits 1,2,3,4,6 -> code=16'h1234 and overflow=1; then '*' -> code=0, digit_count=0, overflow=0.
REQ-037 '#' after 2 digits -> entry_err is high for exactly one cycle and code_valid stays 0; key_value changes 5->6 during PRESS_DB -> the FSM returns to IDLE.
REQ-038 reset_n is pulsed low in PRESS_DB with digit_count=3 -> all outputs are 0 and no event is issued after release.
